// File: rtl/dm_responder_if.sv
// Load/store request and response channels between a pipeline MEM stage (master)
// and the data-memory responder (slave).
interface dm_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_be;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output req_valid, req_write, req_addr, req_wdata, req_be, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, req_be, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/dm_responder.sv
// Multi-cycle data-memory responder: one load/store at a time, WAIT_CYCLES wait states.
// Define DM_ERR_EN to flag misaligned or out-of-range byte addresses on rsp_err.
module dm_responder #(
    parameter int DEPTH       = 1024,
    parameter int ADDR_W      = 10,
    parameter int WAIT_CYCLES = 2
) (
    input  logic          clk,
    input  logic          rst,
    dm_responder_if.slave bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam logic [3:0] WAIT_L = 4'(WAIT_CYCLES);

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              wr_q, wr_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [3:0]        be_q, be_d;
    logic              err_q, err_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              rsp_err_q, rsp_err_d;
    logic              commit_s;
    logic [31:0]       mem_q [DEPTH];

    function automatic logic [31:0] merge_lanes(input logic [31:0] old_w,
                                                input logic [31:0] new_w,
                                                input logic [3:0]  be);
        logic [31:0] res;
        for (int i = 0; i < 4; i++) begin
            res[8*i +: 8] = be[i] ? new_w[8*i +: 8] : old_w[8*i +: 8];
        end
        return res;
    endfunction

    // Control and response registers; the array itself is never reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= 4'd0;
            wr_q      <= 1'b0;
            idx_q     <= {ADDR_W{1'b0}};
            wdata_q   <= 32'h0;
            be_q      <= 4'h0;
            err_q     <= 1'b0;
            rdata_q   <= 32'h0;
            rsp_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            wr_q      <= wr_d;
            idx_q     <= idx_d;
            wdata_q   <= wdata_d;
            be_q      <= be_d;
            err_q     <= err_d;
            rdata_q   <= rdata_d;
            rsp_err_q <= rsp_err_d;
        end
    end

    // Next-state logic; the request is captured only on the accept edge.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wr_d    = wr_q;
        idx_d   = idx_q;
        wdata_d = wdata_q;
        be_d    = be_q;
        err_d   = err_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.req_valid) begin
                    wr_d    = bus.req_write;
                    idx_d   = bus.req_addr[ADDR_W+1:2];
                    wdata_d = bus.req_wdata;
                    be_d    = bus.req_be;
`ifdef DM_ERR_EN
                    err_d   = (bus.req_addr[1:0] != 2'b00) ||
                              (bus.req_addr[31:ADDR_W+2] != {(30-ADDR_W){1'b0}});
`else
                    err_d   = 1'b0;
`endif
                    cnt_d   = WAIT_L;
                    if (WAIT_L != 4'd0) begin
                        state_d = ST_WAIT;
                    end else begin
                        state_d = ST_RESP;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = ST_RESP;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_RESP: begin
                if (bus.rsp_ready) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_RESP;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Commit on the edge into RESP; the *_d values already hold the request in the zero-wait case.
    always_comb begin
        commit_s  = (state_d == ST_RESP) && (state_q != ST_RESP);
        rdata_d   = rdata_q;
        rsp_err_d = rsp_err_q;
        if (commit_s) begin
            rsp_err_d = err_d;
            if (err_d || wr_d) begin
                rdata_d = 32'h0;
            end else begin
                rdata_d = mem_q[idx_d];
            end
        end else begin
            rdata_d   = rdata_q;
            rsp_err_d = rsp_err_q;
        end
    end

    // Array write port; an edge taken while reset is low never commits a store.
    always_ff @(posedge clk) begin
        if (rst && commit_s && wr_d && !err_d) begin
            mem_q[idx_d] <= merge_lanes(mem_q[idx_d], wdata_d, be_d);
        end
    end

    // Handshake outputs decoded from the registered state.
    always_comb begin
        bus.req_ready = (state_q == ST_IDLE);
        bus.rsp_valid = (state_q == ST_RESP);
        bus.rsp_rdata = rdata_q;
        bus.rsp_err   = rsp_err_q;
    end

endmodule

// File: tb/tb_dm_responder.sv
// Randomized self-checking bench for dm_responder against a word-array reference model.
// Honours DM_ERR_EN when defined for the build.
module tb_dm_responder;

    localparam int TB_WAIT = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    dm_responder_if bus();
    dm_responder_if bus0();

    dm_responder #(.DEPTH(1024), .ADDR_W(10), .WAIT_CYCLES(TB_WAIT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    dm_responder #(.DEPTH(1024), .ADDR_W(10), .WAIT_CYCLES(0)) dut0 (
        .clk (clk),
        .rst (rst),
        .bus (bus0)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    logic [31:0] model_mem [1024];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Reference: word array indexed by byte address / 4, modulo 1024 words.
    task automatic model_txn(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                             input logic [3:0] be, output logic [31:0] er, output logic ee);
        int unsigned idx;
        logic [31:0] mask;
        idx = (addr / 4) % 1024;
        ee  = 1'b0;
`ifdef DM_ERR_EN
        ee  = (addr % 4 != 0) || (addr >= 32'h0000_1000);
`endif
        er  = 32'h0;
        mask = 32'h0;
        for (int b = 0; b < 4; b++) if (be[b]) mask = mask | (32'hFF << (8 * b));
        if (!ee) begin
            if (wr) model_mem[idx] = (model_mem[idx] & ~mask) | (wdata & mask);
            else    er = model_mem[idx];
        end
    endtask

    task automatic issue(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] be);
        int budget;
        budget = 0;
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_write = wr;
        bus.req_addr  = addr;
        bus.req_wdata = wdata;
        bus.req_be    = be;
        while (bus.req_ready !== 1'b1 && budget < 50) begin
            @(negedge clk);
            budget++;
        end
        check_eq("accept_ready", {31'h0, bus.req_ready}, 32'h1);
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        bus.req_write = ~wr;
        bus.req_addr  = $urandom;
        bus.req_wdata = $urandom;
        bus.req_be    = 4'($urandom);
    endtask

    task automatic wait_rsp(output int lat);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (bus.rsp_valid !== 1'b1 && lat < 50);
    endtask

    task automatic finish_rsp(input int hold, input logic [31:0] er, input logic ee);
        logic [31:0] first_rdata;
        first_rdata = bus.rsp_rdata;
        for (int h = 0; h < hold; h++) begin
            if (h == 0) begin
                bus.req_valid = 1'b1;
                bus.req_write = 1'b1;
                bus.req_addr  = 32'h0;
                bus.req_wdata = 32'hBAD0_BAD0;
                bus.req_be    = 4'hF;
            end
            @(negedge clk);
            check_eq("hold_valid", {31'h0, bus.rsp_valid}, 32'h1);
            check_eq("hold_rdata", bus.rsp_rdata, first_rdata);
            check_eq("hold_req_ready", {31'h0, bus.req_ready}, 32'h0);
        end
        check_eq("rdata", bus.rsp_rdata, er);
        check_eq("err", {31'h0, bus.rsp_err}, {31'h0, ee});
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.rsp_ready = 1'b0;
        bus.req_valid = 1'b0;
    endtask

    task automatic do_txn(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] be, input int hold);
        logic [31:0] er;
        logic        ee;
        int          lat;
        model_txn(wr, addr, wdata, be, er, ee);
        issue(wr, addr, wdata, be);
        wait_rsp(lat);
        check_eq("latency", lat, TB_WAIT + 1);
        finish_rsp(hold, er, ee);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [31:0] a;
        logic [31:0] vals [4];
        int          lat;
        int          acc;
        int          prev;
        int          budget;
        int unsigned r;

        rst            = 1'b0;
        bus.req_valid  = 1'b1;
        bus.req_write  = 1'b1;
        bus.req_addr   = 32'h0;
        bus.req_wdata  = 32'hFFFF_FFFF;
        bus.req_be     = 4'hF;
        bus.rsp_ready  = 1'b0;
        bus0.req_valid = 1'b0;
        bus0.req_write = 1'b0;
        bus0.req_addr  = 32'h0;
        bus0.req_wdata = 32'h0;
        bus0.req_be    = 4'h0;
        bus0.rsp_ready = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("rst_req_ready", {31'h0, bus.req_ready}, 32'h1);
        check_eq("rst_rsp_valid", {31'h0, bus.rsp_valid}, 32'h0);
        check_eq("rst_rdata", bus.rsp_rdata, 32'h0);
        check_eq("rst_err", {31'h0, bus.rsp_err}, 32'h0);
        bus.req_valid = 1'b0;
        rst = 1'b1;

        // Known contents for every word the bench touches
        for (int i = 0; i < 16; i++) do_txn(1'b1, 32'(i * 4), $urandom, 4'hF, 0);

        do_txn(1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, 0);
        do_txn(1'b0, 32'h10, 32'h0, 4'hF, 0);
        do_txn(1'b1, 32'h20, 32'h1122_3344, 4'hF, 0);
        do_txn(1'b1, 32'h20, 32'hAABB_CCDD, 4'b0101, 1);
        do_txn(1'b0, 32'h20, 32'h0, 4'h0, 5);
        do_txn(1'b1, 32'h14, 32'h5555_AAAA, 4'h0, 0);
        do_txn(1'b0, 32'h14, 32'h0, 4'h3, 2);

        // Reset during WAIT drops an uncommitted store
        do_txn(1'b1, 32'h30, 32'h1234_5678, 4'hF, 0);
        issue(1'b1, 32'h30, 32'hFFFF_FFFF, 4'hF);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_eq("rstw_rsp_valid", {31'h0, bus.rsp_valid}, 32'h0);
        check_eq("rstw_req_ready", {31'h0, bus.req_ready}, 32'h1);
        @(negedge clk);
        rst = 1'b1;
        do_txn(1'b0, 32'h30, 32'h0, 4'hF, 0);

        // Reset during RESP drops the response at once
        issue(1'b0, 32'h10, 32'h0, 4'hF);
        wait_rsp(lat);
        check_eq("rstr_latency", lat, TB_WAIT + 1);
        rst = 1'b0;
        #1;
        check_eq("rstr_rsp_valid", {31'h0, bus.rsp_valid}, 32'h0);
        check_eq("rstr_rdata", bus.rsp_rdata, 32'h0);
        @(negedge clk);
        rst = 1'b1;

        // Misaligned / out-of-range addresses
        do_txn(1'b0, 32'h13, 32'h0, 4'hF, 0);
        do_txn(1'b1, 32'h1000, 32'hCAFE_F00D, 4'hF, 0);
        do_txn(1'b0, 32'h0, 32'h0, 4'hF, 0);

        for (int n = 0; n < 60; n++) begin
            a = 32'($urandom_range(15, 0) * 4);
            r = $urandom_range(3, 0);
`ifdef DM_ERR_EN
            if (r == 0) a = a | 32'($urandom_range(3, 1));
            if (r == 1) a = a | (32'($urandom_range(255, 1)) << 12);
`else
            a = a | 32'(r) | (32'($urandom) << 12);
`endif
            do_txn(1'($urandom), a, $urandom, 4'($urandom), int'($urandom_range(3, 0)));
        end

        // Zero-wait instance: back-to-back stream with rsp_ready held high
        for (int i = 0; i < 4; i++) vals[i] = $urandom;
        bus0.rsp_ready = 1'b1;
        @(negedge clk);
        bus0.req_valid = 1'b1;
        bus0.req_write = 1'b1;
        bus0.req_addr  = 32'h40;
        bus0.req_wdata = vals[0];
        bus0.req_be    = 4'hF;
        prev = 0;
        for (int t = 0; t < 8; t++) begin
            budget = 0;
            while (bus0.req_ready !== 1'b1 && budget < 20) begin
                @(negedge clk);
                budget++;
            end
            check_eq("b2b_accept", {31'h0, bus0.req_ready}, 32'h1);
            acc = cyc;
            if (t > 0) check_eq("b2b_gap", acc - prev, 32'd2);
            prev = acc;
            @(posedge clk);
            #1;
            if (t < 7) begin
                bus0.req_write = (t + 1 < 4);
                bus0.req_addr  = 32'h40 + 32'(((t + 1) % 4) * 4);
                bus0.req_wdata = vals[(t + 1) % 4];
            end else begin
                bus0.req_valid = 1'b0;
            end
            @(negedge clk);
            check_eq("b2b_rsp_valid", {31'h0, bus0.rsp_valid}, 32'h1);
            check_eq("b2b_rdata", bus0.rsp_rdata, (t < 4) ? 32'h0 : vals[t % 4]);
        end
        bus0.rsp_ready = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
